// File: rtl/database_dump_unit_pkg.sv
// -----------------------------------------------------------------------------
// database_dump_unit_pkg
// Shared definitions for the debug-database dump unit:
//   - sizing constants (data word, control code, UART byte)
//   - database control codes (codes 0 and 3 clear the database, never used)
//   - fixed dump order table (PC, PC+4, INSTR, CYCLES)
//   - state encodings of the sequencing FSM and of the word serializer
// -----------------------------------------------------------------------------
package database_dump_unit_pkg;

    localparam int LONGITUD_INSTRUCCION = 32;
    localparam int CANT_BITS_CONTROL    = 3;
    localparam int NB_BYTE              = 8;
    localparam int NUM_WORDS            = 4;

    localparam logic [2:0] CTRL_CAPTURE   = 3'd1;
    localparam logic [2:0] CTRL_PC        = 3'd2;
    localparam logic [2:0] CTRL_PC_PLUS_4 = 3'd4;
    localparam logic [2:0] CTRL_INSTR     = 3'd5;
    localparam logic [2:0] CTRL_CYCLES    = 3'd6;
    // Freezing the database reuses the PC read code: it only selects a field
    // and never clears or advances anything.
    localparam logic [2:0] CTRL_HOLD      = 3'd2;

    // Dump order table: word index -> database read code.
    function automatic logic [2:0] dump_code(input logic [1:0] word_idx);
        case (word_idx)
            2'd0:    dump_code = CTRL_PC;
            2'd1:    dump_code = CTRL_PC_PLUS_4;
            2'd2:    dump_code = CTRL_INSTR;
            default: dump_code = CTRL_CYCLES;
        endcase
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_CODE,
        ST_WAIT_DATA,
        ST_LOAD,
        ST_SERIALIZE,
        ST_NEXT_WORD,
        ST_DONE
    } dump_state_e;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND,
        SER_WAIT_TX
    } ser_state_e;

endpackage

// File: rtl/database_dump_unit_if.sv
// -----------------------------------------------------------------------------
// database_dump_unit_if
// Byte link between the dump unit (master) and the UART transmitter (slave).
//   o_tx_start : master -> slave, one-cycle pulse launching a byte
//   o_tx_data  : master -> slave, byte to send
//   i_tx_done  : slave -> master, one-cycle pulse when the byte has left
// Handshake: the master pulses o_tx_start for exactly one cycle and then holds
// o_tx_data stable until it samples i_tx_done high. A done pulse arriving in
// the start cycle or while no byte is outstanding is ignored by the master.
// At most one byte is outstanding at any time.
// -----------------------------------------------------------------------------
interface database_dump_unit_if #(
    parameter int NB_BYTE = 8
) ();
    logic               o_tx_start;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               i_tx_done;

    modport master (
        output o_tx_start,
        output o_tx_data,
        input  i_tx_done
    );

    modport slave (
        input  o_tx_start,
        input  o_tx_data,
        output i_tx_done
    );
endinterface

// File: rtl/database_dump_unit_word_serializer.sv
// -----------------------------------------------------------------------------
// database_dump_unit_word_serializer
// Loads one data word and sends it MSB-first, one byte at a time, over a
// start/done byte handshake.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i         : capture word_i and start sending (accepted in SER_IDLE)
//   word_i         : word to serialize
//   tx_done_i      : byte finished (counted only in SER_WAIT_TX)
//   tx_start_o     : one-cycle byte launch pulse
//   tx_data_o      : current byte, top byte of the shift register
//   word_done_o    : one-cycle pulse when the last byte is acknowledged
//   state_o        : current serializer state (debug)
// -----------------------------------------------------------------------------
module database_dump_unit_word_serializer
    import database_dump_unit_pkg::*;
#(
    parameter int W  = 32,
    parameter int NB = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [W-1:0]  word_i,
    input  logic          tx_done_i,
    output logic          tx_start_o,
    output logic [NB-1:0] tx_data_o,
    output logic          word_done_o,
    output ser_state_e    state_o
);
    localparam int NUM_BYTES = W / NB;
    localparam int BIDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NUM_BYTES - 1);

    ser_state_e        state_q, state_d;
    logic [W-1:0]      shift_q, shift_d;
    logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SER_IDLE;
            shift_q    <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        tx_start_o  = 1'b0;
        word_done_o = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (load_i) begin
                    shift_d    = word_i;
                    byte_idx_d = '0;
                    state_d    = SER_SEND;
                end
            end
            SER_SEND: begin
                // tx_done_i is deliberately not looked at here: a done in the
                // launch cycle cannot belong to this byte.
                tx_start_o = 1'b1;
                state_d    = SER_WAIT_TX;
            end
            SER_WAIT_TX: begin
                if (tx_done_i) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        word_done_o = 1'b1;
                        state_d     = SER_IDLE;
                    end else begin
                        shift_d    = shift_q << NB;
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = SER_SEND;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // Driven from the register so the byte stays stable until tx_done_i.
    assign tx_data_o = shift_q[W-1 -: NB];
    assign state_o   = state_q;

endmodule

// File: rtl/database_dump_unit.sv
// -----------------------------------------------------------------------------
// database_dump_unit
// Dumps the MIPS debug database over the UART: on i_start it steps the
// database control code through PC, PC+4, INSTR and CYCLES, samples each
// registered data word and sends it as 4 bytes MSB-first. Between dumps the
// database is kept in capture (i_run) or hold mode.
// Ports:
//   i_clock, i_soft_reset : clock, synchronous active-high reset
//   i_run                 : pipeline stepping, database captures every cycle
//   i_start               : one-cycle pulse, begin a full dump
//   i_dato                : registered database data word
//   o_control             : control code to the database (registered)
//   o_busy                : dump in progress
//   o_done                : one-cycle pulse at end of dump
//   o_dbg_state           : sequencing FSM state (debug)
//   o_dbg_ser_state       : serializer state (debug)
//   tx                    : byte link to the UART transmitter (master side)
// -----------------------------------------------------------------------------
module database_dump_unit
    import database_dump_unit_pkg::*;
#(
    parameter int LONGITUD_INSTRUCCION = database_dump_unit_pkg::LONGITUD_INSTRUCCION,
    parameter int CANT_BITS_CONTROL    = database_dump_unit_pkg::CANT_BITS_CONTROL,
    parameter int NB_BYTE              = database_dump_unit_pkg::NB_BYTE
) (
    input  logic                            i_clock,
    input  logic                            i_soft_reset,
    input  logic                            i_run,
    input  logic                            i_start,
    input  logic [LONGITUD_INSTRUCCION-1:0] i_dato,
    output logic [CANT_BITS_CONTROL-1:0]    o_control,
    output logic                            o_busy,
    output logic                            o_done,
    output dump_state_e                     o_dbg_state,
    output ser_state_e                      o_dbg_ser_state,
    database_dump_unit_if.master            tx
);
    localparam logic [1:0] LAST_WORD = 2'(NUM_WORDS - 1);

    dump_state_e                  state_q, state_d;
    logic [1:0]                   word_idx_q, word_idx_d;
    logic [CANT_BITS_CONTROL-1:0] control_q, control_d;
    logic [CANT_BITS_CONTROL-1:0] idle_control;
    logic                         ser_load;
    logic                         ser_word_done;

    assign idle_control = i_run ? CANT_BITS_CONTROL'(CTRL_CAPTURE)
                                : CANT_BITS_CONTROL'(CTRL_HOLD);

    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            control_q  <= CANT_BITS_CONTROL'(CTRL_HOLD);
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            control_q  <= control_d;
        end
    end

    // The read code is registered on the transition into SET_CODE, so it is
    // already on o_control while in SET_CODE and stays there until the word
    // has been fully sent; CAPTURE can never appear mid-dump.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        control_d  = control_q;
        ser_load   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                word_idx_d = '0;
                if (i_start) begin
                    control_d = CANT_BITS_CONTROL'(dump_code(2'd0));
                    state_d   = ST_SET_CODE;
                end else begin
                    control_d = idle_control;
                    state_d   = ST_IDLE;
                end
            end
            ST_SET_CODE:  state_d = ST_WAIT_DATA;
            // Database register updates on the edge closing SET_CODE.
            ST_WAIT_DATA: state_d = ST_LOAD;
            ST_LOAD: begin
                ser_load = 1'b1;
                state_d  = ST_SERIALIZE;
            end
            ST_SERIALIZE: begin
                if (ser_word_done) state_d = ST_NEXT_WORD;
            end
            ST_NEXT_WORD: begin
                if (word_idx_q == LAST_WORD) begin
                    state_d = ST_DONE;
                end else begin
                    word_idx_d = word_idx_q + 2'd1;
                    control_d  = CANT_BITS_CONTROL'(dump_code(word_idx_q + 2'd1));
                    state_d    = ST_SET_CODE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    database_dump_unit_word_serializer #(
        .W  (LONGITUD_INSTRUCCION),
        .NB (NB_BYTE)
    ) u_serializer (
        .clk_i       (i_clock),
        .rst_i       (i_soft_reset),
        .load_i      (ser_load),
        .word_i      (i_dato),
        .tx_done_i   (tx.i_tx_done),
        .tx_start_o  (tx.o_tx_start),
        .tx_data_o   (tx.o_tx_data),
        .word_done_o (ser_word_done),
        .state_o     (o_dbg_ser_state)
    );

    assign o_control   = control_q;
    assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_done      = (state_q == ST_DONE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_database_dump_unit.sv
module tb_database_dump_unit;
    import database_dump_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        run;
    logic        start;
    logic [31:0] dato_q;
    logic [2:0]  control;
    logic        busy;
    logic        done;
    dump_state_e dbg_state;
    ser_state_e  dbg_ser;
    logic        model_done = 1'b0;
    logic        spur_done;

    database_dump_unit_if #(.NB_BYTE(8)) tx_bus ();
    assign tx_bus.i_tx_done = model_done | spur_done;

    database_dump_unit dut (
        .i_clock         (clk),
        .i_soft_reset    (rst),
        .i_run           (run),
        .i_start         (start),
        .i_dato          (dato_q),
        .o_control       (control),
        .o_busy          (busy),
        .o_done          (done),
        .o_dbg_state     (dbg_state),
        .o_dbg_ser_state (dbg_ser),
        .tx              (tx_bus)
    );

    // ---------------- database model (registered read) ----------------
    function automatic logic [31:0] db_read(input logic [2:0] c);
        case (c)
            3'd1:    db_read = 32'hCAFE_F00D;
            3'd2:    db_read = 32'h0000_0010;
            3'd4:    db_read = 32'h0000_0014;
            3'd5:    db_read = 32'h8C22_0004;
            3'd6:    db_read = 32'h0000_002A;
            default: db_read = 32'h0000_0000;
        endcase
    endfunction

    always @(posedge clk) dato_q <= db_read(control);

    // ---------------- UART TX model: done 3 cycles after each start ----------------
    int tx_cnt = 0;
    always @(negedge clk) begin
        if (tx_cnt > 0) begin
            tx_cnt     = tx_cnt - 1;
            model_done = (tx_cnt == 0);
        end else begin
            model_done = 1'b0;
        end
        if (tx_bus.o_tx_start === 1'b1) tx_cnt = 3;
    end

    // ---------------- monitor ----------------
    logic [7:0] got_q[$];
    logic [2:0] ctrl_got_q[$];
    int done_cnt = 0;
    int bad_ctrl = 0;
    int capture_in_dump = 0;
    logic mon_en = 1'b0;

    always @(negedge clk) begin
        if (tx_bus.o_tx_start === 1'b1) begin
            got_q.push_back(tx_bus.o_tx_data);
            ctrl_got_q.push_back(control);
        end
        if (done === 1'b1) done_cnt++;
        if (mon_en && (control == 3'd0 || control == 3'd3)) bad_ctrl++;
        if (mon_en && busy === 1'b1 && control == CTRL_CAPTURE) capture_in_dump++;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    localparam logic [7:0] EXP_BYTES [16] = '{
        8'h00, 8'h00, 8'h00, 8'h10,
        8'h00, 8'h00, 8'h00, 8'h14,
        8'h8C, 8'h22, 8'h00, 8'h04,
        8'h00, 8'h00, 8'h00, 8'h2A
    };
    localparam logic [2:0] EXP_CODES [4] = '{3'd2, 3'd4, 3'd5, 3'd6};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        if (i == budget) timeout_fail(name);
    endtask

    task automatic wait_state(input string name, input dump_state_e s, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dbg_state == s) break;
        end
        if (i == budget) timeout_fail(name);
    endtask

    task automatic wait_ser(input string name, input ser_state_e s, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dbg_ser == s) break;
        end
        if (i == budget) timeout_fail(name);
    endtask

    task automatic check_dump(input string tag, input int base);
        check($sformatf("%s_byte_count", tag), 32'(got_q.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < got_q.size()) begin
                check($sformatf("%s_byte%0d", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
                check($sformatf("%s_ctrl_byte%0d", tag, i), 32'(ctrl_got_q[base + i]),
                      32'(EXP_CODES[i / 4]));
            end
        end
    endtask

    // ---------------- idle-mode vector table ----------------
    typedef struct {
        logic       run;
        logic [2:0] exp_ctrl;
        logic       exp_busy;
    } idle_vec_t;

    idle_vec_t vecs[4];

    initial begin
        int base;
        int dbase;

        vecs[0] = '{run: 1'b1, exp_ctrl: 3'd1, exp_busy: 1'b0};
        vecs[1] = '{run: 1'b0, exp_ctrl: 3'd2, exp_busy: 1'b0};
        vecs[2] = '{run: 1'b1, exp_ctrl: 3'd1, exp_busy: 1'b0};
        vecs[3] = '{run: 1'b0, exp_ctrl: 3'd2, exp_busy: 1'b0};
        for (int i = 0; i < 16; i++) exp_q.push_back(EXP_BYTES[i]);

        // reset
        rst = 1'b1; run = 1'b0; start = 1'b0; spur_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_control", 32'(control), 32'd2);
        check("rst_tx_start", 32'(tx_bus.o_tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_bus.o_tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        mon_en = 1'b1;

        // idle capture/hold table
        for (int i = 0; i < 4; i++) begin
            run = vecs[i].run;
            @(negedge clk);
            check($sformatf("idle_vec%0d_control", i), 32'(control), 32'(vecs[i].exp_ctrl));
            check($sformatf("idle_vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
        end

        // full dump with latency check
        base = got_q.size();
        dbase = done_cnt;
        pulse_start();
        check("lat_control_c1", 32'(control), 32'd2);
        check("lat_busy_c1", 32'(busy), 32'd1);
        check("lat_tx_start_c1", 32'(tx_bus.o_tx_start), 32'd0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("lat_tx_start_c%0d", c), 32'(tx_bus.o_tx_start), (c == 4) ? 32'd1 : 32'd0);
        end
        check("lat_tx_data_c4", 32'(tx_bus.o_tx_data), 32'h00);
        wait_done("dump1_done", 300);
        repeat (3) @(negedge clk);
        check("dump1_done_pulses", 32'(done_cnt - dbase), 32'd1);
        check("dump1_busy_after", 32'(busy), 32'd0);
        check("dump1_control_after", 32'(control), 32'd2);
        check_dump("dump1", base);

        // re-start mid dump, spurious done in SET_CODE and in the SEND cycle
        base = got_q.size();
        dbase = done_cnt;
        pulse_start();
        wait_state("mid_wait_serialize", ST_SERIALIZE, 50);
        pulse_start();
        wait_state("mid_wait_set_code", ST_SET_CODE, 100);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        wait_ser("mid_wait_send", SER_SEND, 50);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        wait_done("dump2_done", 300);
        repeat (3) @(negedge clk);
        check("dump2_done_pulses", 32'(done_cnt - dbase), 32'd1);
        check_dump("dump2", base);

        // reset after the sixth byte
        base = got_q.size();
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            if (got_q.size() - base >= 6) break;
            @(negedge clk);
        end
        if (got_q.size() - base < 6) timeout_fail("rst_mid_wait_byte6");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_control", 32'(control), 32'd2);
        check("rstmid_tx_start", 32'(tx_bus.o_tx_start), 32'd0);
        check("rstmid_tx_data", 32'(tx_bus.o_tx_data), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rstmid_ser_state", 32'(dbg_ser), 32'(SER_IDLE));
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rstmid_byte_count", 32'(got_q.size() - base), 32'd6);
        check("rstmid_idle_busy", 32'(busy), 32'd0);
        base = got_q.size();
        dbase = done_cnt;
        pulse_start();
        wait_done("dump3_done", 300);
        repeat (3) @(negedge clk);
        check("dump3_done_pulses", 32'(done_cnt - dbase), 32'd1);
        check_dump("dump3", base);

        // start together with run: dump wins, no CAPTURE until done
        run = 1'b1;
        repeat (2) @(negedge clk);
        check("runstart_control_before", 32'(control), 32'd1);
        base = got_q.size();
        dbase = done_cnt;
        capture_in_dump = 0;
        pulse_start();
        check("runstart_control_c1", 32'(control), 32'd2);
        check("runstart_busy_c1", 32'(busy), 32'd1);
        wait_done("dump4_done", 300);
        repeat (3) @(negedge clk);
        check("runstart_capture_in_dump", 32'(capture_in_dump), 32'd0);
        check("runstart_control_after", 32'(control), 32'd1);
        check("dump4_done_pulses", 32'(done_cnt - dbase), 32'd1);
        check_dump("dump4", base);
        run = 1'b0;
        repeat (2) @(negedge clk);

        check("never_clear_code", 32'(bad_ctrl), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
